// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port 16-bit RAM between port A (CPU bus) and
// port B (DMA/loader).
//
// Every access is a 3-cycle transaction: IDLE (grant and latch the request
// onto the RAM pins), ACCESS (the RAM samples at the closing edge) and
// RESPOND (return read data, pulse ready). Because read data is taken in
// RESPOND, the RAM's 1-cycle registered read latency is invisible to the
// requesters. Write masks are active-low per byte and pass through unchanged.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   x_req                 level request, held until x_ready (x = a or b)
//   x_we                  1 = write, 0 = read
//   x_address             byte address (bit 0 ignored by the RAM)
//   x_data_in             write data
//   x_write_mask          active-low: bit0 masks [15:8], bit1 masks [7:0]
//   x_data_out            read data, valid while x_ready = 1
//   x_ready               one-cycle completion pulse
//   ram_*                 RAM address / write data / mask / write enable
//   ram_data_out          RAM read data (registered, 1-cycle latency)
//   busy                  high while a transaction is in flight
//
// Parameters:
//   FIXED_PRIORITY        0 = round-robin on ties, 1 = A always wins ties
//   ADDRESS_WIDTH         byte address width
module ram_arbiter #(
  parameter bit          FIXED_PRIORITY = 1'b0,
  parameter int unsigned ADDRESS_WIDTH  = 12
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     a_req,
  input  logic                     a_we,
  input  logic [ADDRESS_WIDTH-1:0] a_address,
  input  logic [15:0]              a_data_in,
  input  logic [1:0]               a_write_mask,
  output logic [15:0]              a_data_out,
  output logic                     a_ready,

  input  logic                     b_req,
  input  logic                     b_we,
  input  logic [ADDRESS_WIDTH-1:0] b_address,
  input  logic [15:0]              b_data_in,
  input  logic [1:0]               b_write_mask,
  output logic [15:0]              b_data_out,
  output logic                     b_ready,

  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic [15:0]              ram_data_in,
  output logic [1:0]               ram_write_mask,
  output logic                     ram_write_enable,
  input  logic [15:0]              ram_data_out,

  output logic                     busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StRespond} state_e;

  state_e state_q;
  logic   grant_b_q;       // owner of the transaction in flight (1 = B)
  logic   last_grant_b_q;  // owner of the most recently completed transaction
  logic   we_q;            // kept after ram_write_enable drops, selects read return

  logic   a_eligible;
  logic   b_eligible;
  logic   pick_b;

  // A port is not eligible in the cycle its ready pulse is visible; the
  // requester only learns about completion then, so a still-high req in that
  // cycle is stale. The other port may be granted in that same cycle.
  always_comb begin
    a_eligible = a_req & ~a_ready;
    b_eligible = b_req & ~b_ready;
    pick_b     = b_eligible & (~a_eligible | (~FIXED_PRIORITY & ~last_grant_b_q));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= StIdle;
      grant_b_q        <= 1'b0;
      last_grant_b_q   <= 1'b1;  // A wins the first tie after reset
      we_q             <= 1'b0;
      a_ready          <= 1'b0;
      b_ready          <= 1'b0;
      a_data_out       <= '0;
      b_data_out       <= '0;
      ram_address      <= '0;
      ram_data_in      <= '0;
      ram_write_mask   <= 2'b11;
      ram_write_enable <= 1'b0;
      busy             <= 1'b0;
    end else begin
      a_ready <= 1'b0;
      b_ready <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (a_eligible || b_eligible) begin
            grant_b_q        <= pick_b;
            we_q             <= pick_b ? b_we : a_we;
            ram_address      <= pick_b ? b_address : a_address;
            ram_data_in      <= pick_b ? b_data_in : a_data_in;
            ram_write_mask   <= pick_b ? b_write_mask : a_write_mask;
            ram_write_enable <= pick_b ? b_we : a_we;
            busy             <= 1'b1;
            state_q          <= StAccess;
          end
        end

        // The RAM performs the write or captures read data at this edge.
        StAccess: begin
          ram_write_enable <= 1'b0;
          state_q          <= StRespond;
        end

        StRespond: begin
          if (grant_b_q) begin
            b_ready <= 1'b1;
            if (!we_q) begin
              b_data_out <= ram_data_out;
            end
          end else begin
            a_ready <= 1'b1;
            if (!we_q) begin
              a_data_out <= ram_data_out;
            end
          end
          last_grant_b_q <= grant_b_q;
          busy           <= 1'b0;
          state_q        <= StIdle;
        end

        default: begin
          ram_write_enable <= 1'b0;
          busy             <= 1'b0;
          state_q          <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter. Two instances run side by side: index 0 uses
// round-robin, index 1 fixed priority. Each has its own behavioural RAM and
// its own transaction-level reference model, checked every cycle.
module tb_ram_arbiter;

  localparam int AW = 12;
  localparam int NW = 1 << (AW - 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          a_req  [2];
  logic          a_we   [2];
  logic [AW-1:0] a_addr [2];
  logic [15:0]   a_din  [2];
  logic [1:0]    a_mask [2];
  logic [15:0]   a_dout [2];
  logic          a_rdy  [2];
  logic          b_req  [2];
  logic          b_we   [2];
  logic [AW-1:0] b_addr [2];
  logic [15:0]   b_din  [2];
  logic [1:0]    b_mask [2];
  logic [15:0]   b_dout [2];
  logic          b_rdy  [2];
  logic [AW-1:0] r_addr [2];
  logic [15:0]   r_din  [2];
  logic [1:0]    r_mask [2];
  logic          r_we   [2];
  logic [15:0]   r_dout [2];
  logic          busy   [2];

  ram_arbiter #(.FIXED_PRIORITY(1'b0), .ADDRESS_WIDTH(AW)) u_dut_rr (
    .clk(clk), .reset(reset),
    .a_req(a_req[0]), .a_we(a_we[0]), .a_address(a_addr[0]), .a_data_in(a_din[0]),
    .a_write_mask(a_mask[0]), .a_data_out(a_dout[0]), .a_ready(a_rdy[0]),
    .b_req(b_req[0]), .b_we(b_we[0]), .b_address(b_addr[0]), .b_data_in(b_din[0]),
    .b_write_mask(b_mask[0]), .b_data_out(b_dout[0]), .b_ready(b_rdy[0]),
    .ram_address(r_addr[0]), .ram_data_in(r_din[0]), .ram_write_mask(r_mask[0]),
    .ram_write_enable(r_we[0]), .ram_data_out(r_dout[0]), .busy(busy[0])
  );

  ram_arbiter #(.FIXED_PRIORITY(1'b1), .ADDRESS_WIDTH(AW)) u_dut_fp (
    .clk(clk), .reset(reset),
    .a_req(a_req[1]), .a_we(a_we[1]), .a_address(a_addr[1]), .a_data_in(a_din[1]),
    .a_write_mask(a_mask[1]), .a_data_out(a_dout[1]), .a_ready(a_rdy[1]),
    .b_req(b_req[1]), .b_we(b_we[1]), .b_address(b_addr[1]), .b_data_in(b_din[1]),
    .b_write_mask(b_mask[1]), .b_data_out(b_dout[1]), .b_ready(b_rdy[1]),
    .ram_address(r_addr[1]), .ram_data_in(r_din[1]), .ram_write_mask(r_mask[1]),
    .ram_write_enable(r_we[1]), .ram_data_out(r_dout[1]), .busy(busy[1])
  );

  // Behavioural single-port RAMs with registered read data.
  logic [15:0] ram_mem [2][NW];
  bit          mem_cleared = 1'b0;
  always @(posedge clk) begin
    if (!mem_cleared) begin
      for (int i = 0; i < 2; i++) for (int w = 0; w < NW; w++) ram_mem[i][w] <= '0;
      mem_cleared <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_we[i]) begin
          if (!r_mask[i][0]) ram_mem[i][r_addr[i][AW-1:1]][15:8] <= r_din[i][15:8];
          if (!r_mask[i][1]) ram_mem[i][r_addr[i][AW-1:1]][7:0]  <= r_din[i][7:0];
        end
        r_dout[i] <= ram_mem[i][r_addr[i][AW-1:1]];
      end
    end
  end

  // ---------------- reference model (transaction timeline) ----------------
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  bit            rv     [2];  // a transaction has been granted
  int            rg     [2];  // cycle in which it was granted
  bit            rport  [2];  // 1 = B
  bit            rwe    [2];
  logic [15:0]   rres   [2];
  bit            last_b [2];
  logic [AW-1:0] e_addr [2];
  logic [15:0]   e_din  [2];
  logic [1:0]    e_mask [2];
  logic [15:0]   e_adout[2];
  logic [15:0]   e_bdout[2];
  bit            e_ardy [2];
  bit            e_brdy [2];
  logic [15:0]   mem_ref[2][NW];

  function automatic logic [15:0] apply_mask(input logic [15:0] old, input logic [15:0] d,
                                             input logic [1:0] m);
    apply_mask = old;
    if (!m[0]) apply_mask[15:8] = d[15:8];
    if (!m[1]) apply_mask[7:0]  = d[7:0];
  endfunction

  task automatic cmp(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cyc=%0d actual=%h required=%h", name, inst, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0;  last_b[i] = 1'b1;
      e_addr[i] = '0; e_din[i] = '0; e_mask[i] = 2'b11;
      e_adout[i] = '0; e_bdout[i] = '0; e_ardy[i] = 1'b0; e_brdy[i] = 1'b0;
    end
  endtask

  // Expected outputs for the current cycle, compared against both DUTs.
  task automatic check();
    for (int i = 0; i < 2; i++) begin
      int d;
      bit ebusy, ewe;
      d        = cyc - rg[i];
      ebusy    = rv[i] && (d == 1 || d == 2);
      ewe      = rv[i] && d == 1 && rwe[i];
      e_ardy[i] = rv[i] && d == 3 && !rport[i];
      e_brdy[i] = rv[i] && d == 3 && rport[i];
      if (rv[i] && d == 3) begin
        last_b[i] = rport[i];
        if (!rwe[i]) begin
          if (rport[i]) e_bdout[i] = rres[i];
          else          e_adout[i] = rres[i];
        end
      end
      cmp("busy", i, 32'(busy[i]), 32'(ebusy));
      cmp("ram_we", i, 32'(r_we[i]), 32'(ewe));
      cmp("ram_addr", i, 32'(r_addr[i]), 32'(e_addr[i]));
      cmp("ram_din", i, 32'(r_din[i]), 32'(e_din[i]));
      cmp("ram_mask", i, 32'(r_mask[i]), 32'(e_mask[i]));
      cmp("a_ready", i, 32'(a_rdy[i]), 32'(e_ardy[i]));
      cmp("b_ready", i, 32'(b_rdy[i]), 32'(e_brdy[i]));
      cmp("a_dout", i, 32'(a_dout[i]), 32'(e_adout[i]));
      cmp("b_dout", i, 32'(b_dout[i]), 32'(e_bdout[i]));
    end
  endtask

  // Grant decision at the edge closing the current cycle.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit            ea, eb, pb, we;
      logic [AW-1:0] ad;
      logic [15:0]   da;
      logic [1:0]    mk;
      int            w;
      if (rv[i] && (cyc - rg[i]) < 3) continue;
      ea = a_req[i] && !e_ardy[i];
      eb = b_req[i] && !e_brdy[i];
      if (!(ea || eb)) continue;
      pb = eb && (!ea || (i == 0 && !last_b[i]));
      we = pb ? b_we[i] : a_we[i];
      ad = pb ? b_addr[i] : a_addr[i];
      da = pb ? b_din[i] : a_din[i];
      mk = pb ? b_mask[i] : a_mask[i];
      rv[i] = 1'b1; rg[i] = cyc; rport[i] = pb; rwe[i] = we;
      e_addr[i] = ad; e_din[i] = da; e_mask[i] = mk;
      w = int'(ad[AW-1:1]);
      if (we) mem_ref[i][w] = apply_mask(mem_ref[i][w], da, mk);
      else    rres[i] = mem_ref[i][w];
    end
  endtask

  task automatic tick();
    model_edge();
    @(negedge clk);
    cyc++;
    check();
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_port(input int i, input bit p, input bit rq, input bit we,
                          input logic [AW-1:0] ad, input logic [15:0] da,
                          input logic [1:0] mk);
    if (p) begin
      b_req[i] = rq; b_we[i] = we; b_addr[i] = ad; b_din[i] = da; b_mask[i] = mk;
    end else begin
      a_req[i] = rq; a_we[i] = we; a_addr[i] = ad; a_din[i] = da; a_mask[i] = mk;
    end
  endtask

  task automatic drive_port(input bit p, input bit rq, input bit we,
                            input logic [AW-1:0] ad, input logic [15:0] da,
                            input logic [1:0] mk);
    for (int i = 0; i < 2; i++) set_port(i, p, rq, we, ad, da, mk);
  endtask

  function automatic bit rdy(input int i, input bit p);
    return p ? b_rdy[i] : a_rdy[i];
  endfunction

  // One complete access on one port of both DUTs, then the port goes idle.
  task automatic do_op(input bit p, input bit we, input logic [AW-1:0] ad,
                       input logic [15:0] da, input logic [1:0] mk,
                       output logic [15:0] rd0, output logic [15:0] rd1, output int lat);
    drive_port(p, 1'b1, we, ad, da, mk);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!(rdy(0, p) && rdy(1, p)) && lat < 10);
    rd0 = p ? b_dout[0] : a_dout[0];
    rd1 = p ? b_dout[1] : a_dout[1];
    drive_port(p, 1'b0, 1'b0, '0, '0, 2'b11);
    tick();
  endtask

  // Requesters follow the handshake: hold until ready, then drop or re-request.
  task automatic requester(input bit allow_new);
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        bit rq;
        rq = (p == 1) ? b_req[i] : a_req[i];
        if (rq && rdy(i, p[0])) begin
          if (allow_new && $urandom_range(0, 1) == 1)
            set_port(i, p[0], 1'b1, 1'($urandom), AW'($urandom_range(0, 31)),
                     16'($urandom), 2'($urandom));
          else
            set_port(i, p[0], 1'b0, 1'b0, '0, '0, 2'b11);
        end else if (!rq && allow_new && $urandom_range(0, 2) == 0) begin
          set_port(i, p[0], 1'b1, 1'($urandom),
                   ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31)),
                   16'($urandom), 2'($urandom));
        end
      end
    end
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) begin
      requester(1'b0);
      tick();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] rd0, rd1;
    int          lat;

    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < NW; w++) mem_ref[i][w] = '0;
      set_port(i, 1'b0, 1'b0, 1'b0, '0, '0, 2'b11);
      set_port(i, 1'b1, 1'b0, 1'b0, '0, '0, 2'b11);
    end
    model_reset();

    // Reset state
    #2 reset = 1'b0;
    @(negedge clk);
    check();
    for (int i = 0; i < 2; i++) begin
      cmp("rst_busy", i, 32'(busy[i]), 32'd0);
      cmp("rst_mask", i, 32'(r_mask[i]), 32'd3);
      cmp("rst_ready", i, 32'({a_rdy[i], b_rdy[i]}), 32'd0);
    end
    @(negedge clk);
    cyc++;
    check();
    reset = 1'b1;
    tick();

    // Write then read back on A
    do_op(1'b0, 1'b1, 12'h010, 16'hBEEF, 2'b00, rd0, rd1, lat);
    cmp("wr_latency", 0, 32'(lat), 32'd3);
    do_op(1'b0, 1'b0, 12'h010, 16'h0000, 2'b11, rd0, rd1, lat);
    cmp("rd_latency", 0, 32'(lat), 32'd3);
    cmp("rd_beef", 0, 32'(rd0), 32'h0000_BEEF);
    cmp("rd_beef", 1, 32'(rd1), 32'h0000_BEEF);

    // Byte mask: bit1 protects the low byte
    do_op(1'b0, 1'b1, 12'h020, 16'h1234, 2'b00, rd0, rd1, lat);
    do_op(1'b0, 1'b1, 12'h020, 16'hAB00, 2'b10, rd0, rd1, lat);
    do_op(1'b0, 1'b0, 12'h020, 16'h0000, 2'b11, rd0, rd1, lat);
    cmp("mask_rd", 0, 32'(rd0), 32'h0000_AB34);
    cmp("mask_rd", 1, 32'(rd1), 32'h0000_AB34);

    // Fully masked write still completes and changes nothing
    do_op(1'b0, 1'b1, 12'h010, 16'h0000, 2'b11, rd0, rd1, lat);
    cmp("mask11_latency", 0, 32'(lat), 32'd3);
    do_op(1'b0, 1'b0, 12'h010, 16'h0000, 2'b11, rd0, rd1, lat);
    cmp("mask11_rd", 0, 32'(rd0), 32'h0000_BEEF);

    // Both ports read continuously; last grant was A. Round-robin starts
    // with B, fixed priority with A; after that the completing port is
    // ineligible, so both instances alternate every 3 cycles.
    drive_port(1'b0, 1'b1, 1'b0, 12'h010, 16'h0000, 2'b11);
    drive_port(1'b1, 1'b1, 1'b0, 12'h020, 16'h0000, 2'b11);
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k % 3 == 0) begin
        cmp("alt_order", 0, 32'({a_rdy[0], b_rdy[0]}), ((k / 3) % 2 == 1) ? 32'd1 : 32'd2);
        cmp("alt_order", 1, 32'({a_rdy[1], b_rdy[1]}), ((k / 3) % 2 == 1) ? 32'd2 : 32'd1);
      end
      if (k == 3) begin
        cmp("alt_b_data", 0, 32'(b_dout[0]), 32'h0000_AB34);
        cmp("alt_a_data", 1, 32'(a_dout[1]), 32'h0000_BEEF);
      end
      if (k == 18) begin
        drive_port(1'b0, 1'b0, 1'b0, '0, '0, 2'b11);
        drive_port(1'b1, 1'b0, 1'b0, '0, '0, 2'b11);
      end
    end
    tick();
    tick();

    // B write with bit0 set: only the low byte lands
    do_op(1'b1, 1'b1, 12'h030, 16'h5A5A, 2'b01, rd0, rd1, lat);
    do_op(1'b1, 1'b0, 12'h030, 16'h0000, 2'b11, rd0, rd1, lat);
    cmp("b_mask_rd", 0, 32'(rd0), 32'h0000_005A);
    cmp("b_mask_rd", 1, 32'(rd1), 32'h0000_005A);

    // Address change after grant is ignored
    drive_port(1'b0, 1'b1, 1'b0, 12'h010, 16'h0000, 2'b11);
    tick();
    cmp("latched_addr", 0, 32'(r_addr[0]), 32'h010);
    drive_port(1'b0, 1'b1, 1'b0, 12'h020, 16'h0000, 2'b11);
    tick();
    cmp("latched_addr_hold", 0, 32'(r_addr[0]), 32'h010);
    tick();
    cmp("latched_ready", 0, 32'(a_rdy[0]), 32'd1);
    cmp("latched_data", 0, 32'(a_dout[0]), 32'h0000_BEEF);
    drive_port(1'b0, 1'b0, 1'b0, '0, '0, 2'b11);
    tick();

    // Reset during ACCESS of a B read, with A waiting
    drive_port(1'b1, 1'b1, 1'b0, 12'h020, 16'h0000, 2'b11);
    tick();
    cmp("pre_rst_busy", 0, 32'(busy[0]), 32'd1);
    drive_port(1'b0, 1'b1, 1'b0, 12'h010, 16'h0000, 2'b11);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      cmp("abort_busy", i, 32'(busy[i]), 32'd0);
      cmp("abort_b_ready", i, 32'(b_rdy[i]), 32'd0);
      cmp("abort_ram_we", i, 32'(r_we[i]), 32'd0);
    end
    model_reset();
    @(negedge clk);
    cyc++;
    check();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) cmp("post_rst_grant_a", i, 32'(r_addr[i]), 32'h010);
    settle(12);

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      requester(1'b1);
      tick();
    end
    settle(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
